// File: rtl/game_tick_scheduler_pkg.sv
// Shared state encoding, channel sizing and reset periods for the tick scheduler.
package game_tick_scheduler_pkg;

   localparam int NCH = 4;
   localparam int PW  = 8;
   localparam int SW  = $clog2(NCH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   typedef logic [PW-1:0] period_t;

   localparam period_t P0 = 8'd5;
   localparam period_t P1 = 8'd2;
   localparam period_t P2 = 8'd100;
   localparam period_t P3 = 8'd50;

   function automatic period_t rst_period(input int ch);
      case (ch)
         0:       return P0;
         1:       return P1;
         2:       return P2;
         default: return P3;
      endcase
   endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Command, config and status bundle between the scheduler and its host.
interface game_tick_scheduler_if
   import game_tick_scheduler_pkg::*;
#(
   parameter int ELW = 16
);
   logic           tick_10ms;
   logic           start;
   logic           pause;
   logic           stop;
   logic           cfg_we;
   logic [SW-1:0]  cfg_sel;
   period_t        cfg_period;
   logic [NCH-1:0] fire;
   logic           running;
   logic           paused;
   logic [ELW-1:0] elapsed;

   modport master (
      output tick_10ms, start, pause, stop, cfg_we, cfg_sel, cfg_period,
      input  fire, running, paused, elapsed
   );

   modport slave (
      input  tick_10ms, start, pause, stop, cfg_we, cfg_sel, cfg_period,
      output fire, running, paused, elapsed
   );
endinterface

// File: rtl/game_tick_scheduler_sched_channel.sv
// One periodic task channel: period register, tick counter and registered fire pulse.
// Fire appears one cycle after the qualifying tick; no backpressure.
module sched_channel
   import game_tick_scheduler_pkg::*;
#(
   parameter period_t P_RST = 8'd1
) (
   input  logic    clk_100mhz,
   input  logic    rst_n,
   input  logic    tick_i,
   input  logic    clr_i,
   input  logic    cfg_we_i,
   input  period_t cfg_period_i,
   output logic    fire_o
);

   period_t period_q, period_d;
   period_t cnt_q, cnt_d;
   logic    fire_q, fire_d;

   always_comb begin
      period_d = period_q;
      cnt_d    = cnt_q;
      fire_d   = 1'b0;
      if (cfg_we_i) begin
         // A config write restarts the channel and swallows this cycle's tick.
         period_d = cfg_period_i;
         cnt_d    = '0;
      end else if (tick_i && (period_q != '0)) begin
         if (cnt_q == period_q - period_t'(1)) begin
            cnt_d  = '0;
            fire_d = 1'b1;
         end else begin
            cnt_d = cnt_q + period_t'(1);
         end
      end
      if (clr_i) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         period_q <= P_RST;
         cnt_q    <= '0;
         fire_q   <= 1'b0;
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         fire_q   <= fire_d;
      end
   end

   assign fire_o = fire_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// RUN/PAUSE/IDLE gate over the 10 ms strobe feeding NCH periodic step channels and
// a saturating elapsed counter; all outputs registered, one cycle after the tick.
module game_tick_scheduler
   import game_tick_scheduler_pkg::*;
#(
   parameter int ELW = 16
) (
   input  logic                  clk_100mhz,
   input  logic                  rst_n,
   game_tick_scheduler_if.slave  bus
);

   localparam logic [ELW-1:0] EL_MAX = '1;

   logic [1:0]     state_q, state_d;
   logic [ELW-1:0] elapsed_q, elapsed_d;
   logic           running_q, paused_q;
   logic           fresh;
   logic           clr;
   logic           tick_run;
   logic [NCH-1:0] fire;

   always_comb begin
      state_d = state_q;
      fresh   = 1'b0;
      if (bus.stop) begin
         state_d = ST_IDLE;
      end else begin
         // pause outranks start even where pause itself has no effect
         case (state_q)
            ST_IDLE:  if (!bus.pause && bus.start) begin
                         state_d = ST_RUN;
                         fresh   = 1'b1;
                      end
            ST_RUN:   if (bus.pause) state_d = ST_PAUSE;
            ST_PAUSE: if (!bus.pause && bus.start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Qualified on the registered state, so a tick alongside pause/stop still counts.
   assign tick_run = bus.tick_10ms && (state_q == ST_RUN);
   assign clr      = bus.stop || fresh;

   always_comb begin
      elapsed_d = elapsed_q;
      if (fresh) begin
         elapsed_d = '0;
      end else if (tick_run && (elapsed_q != EL_MAX)) begin
         elapsed_d = elapsed_q + 1'b1;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         elapsed_q <= '0;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         elapsed_q <= elapsed_d;
         running_q <= (state_d == ST_RUN);
         paused_q  <= (state_d == ST_PAUSE);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      sched_channel #(
         .P_RST (rst_period(g))
      ) u_ch (
         .clk_100mhz   (clk_100mhz),
         .rst_n        (rst_n),
         .tick_i       (tick_run),
         .clr_i        (clr),
         .cfg_we_i     (bus.cfg_we && (bus.cfg_sel == SW'(g))),
         .cfg_period_i (bus.cfg_period),
         .fire_o       (fire[g])
      );
   end

   assign bus.fire    = fire;
   assign bus.running = running_q;
   assign bus.paused  = paused_q;
   assign bus.elapsed = elapsed_q;

endmodule
